// File: rtl/ex_hazard_stall_unit.sv
// Hazard controller fed by the EX-stage control registers: load-use bubbles,
// taken-branch flushes and a multi-cycle mul/div wait with a saturating stall counter.
module ex_hazard_stall_unit #(
  parameter int unsigned RegAddrBits  = 5,
  parameter int unsigned MulDivCycles = 32,
  parameter int unsigned StatBits     = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   clock_enable_i,
  input  logic                   tick_i,
  input  logic [RegAddrBits-1:0] id_rs1_i,
  input  logic [RegAddrBits-1:0] id_rs2_i,
  input  logic                   id_uses_rs1_i,
  input  logic                   id_uses_rs2_i,
  input  logic                   ex_reg_write_i,
  input  logic                   ex_mem_read_i,
  input  logic [RegAddrBits-1:0] ex_rd_i,
  input  logic                   ex_mul_div_start_i,
  input  logic                   ex_branch_taken_i,
  output logic                   stall_pc_o,
  output logic                   stall_if_id_o,
  output logic                   stall_id_ex_o,
  output logic                   flush_if_id_o,
  output logic                   flush_id_ex_o,
  output logic                   mul_div_busy_o,
  output logic [StatBits-1:0]    load_use_stalls_o
);

  typedef enum logic {
    RUN         = 1'b0,
    MULDIV_WAIT = 1'b1
  } state_e;

  // The start cycle is itself a stall, so the counter covers the remaining cycles.
  localparam logic [7:0]          CntLoad = 8'(MulDivCycles - 1);
  localparam logic [StatBits-1:0] StatMax = '1;

  generate
    if (MulDivCycles < 1 || MulDivCycles > 255) begin : g_bad_muldiv_cycles
      $error("MulDivCycles must lie in 1..255");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [StatBits-1:0] lu_stalls_q, lu_stalls_d;

  logic advance;
  logic rs1_hit, rs2_hit, load_use;
  logic stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, busy;

  assign advance  = clock_enable_i & tick_i;
  assign rs1_hit  = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit  = id_uses_rs2_i & (id_rs2_i == ex_rd_i);
  assign load_use = ex_reg_write_i & ex_mem_read_i & (ex_rd_i != '0) & (rs1_hit | rs2_hit);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lu_stalls_d = lu_stalls_q;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    stall_id_ex = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    busy        = 1'b0;

    case (state_q)
      RUN: begin
        if (ex_branch_taken_i) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (ex_mul_div_start_i) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          stall_id_ex = 1'b1;
          state_d     = MULDIV_WAIT;
          cnt_d       = CntLoad;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (lu_stalls_q != StatMax) begin
            lu_stalls_d = lu_stalls_q + StatBits'(1);
          end
        end
      end

      MULDIV_WAIT: begin
        busy = 1'b1;
        if (cnt_q != 8'd0) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          stall_id_ex = 1'b1;
          cnt_d       = cnt_q - 8'd1;
        end else begin
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= RUN;
      cnt_q       <= 8'd0;
      lu_stalls_q <= '0;
    end else if (advance) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lu_stalls_q <= lu_stalls_d;
    end
  end

  // Mask while reset is held so stalls drop in the same cycle reset rises.
  assign stall_pc_o        = stall_pc    & ~reset_i;
  assign stall_if_id_o     = stall_if_id & ~reset_i;
  assign stall_id_ex_o     = stall_id_ex & ~reset_i;
  assign flush_if_id_o     = flush_if_id & ~reset_i;
  assign flush_id_ex_o     = flush_id_ex & ~reset_i;
  assign mul_div_busy_o    = busy        & ~reset_i;
  assign load_use_stalls_o = lu_stalls_q;

endmodule

// File: doc/ex_hazard_stall_unit.md
Name: ex_hazard_stall_unit

Overview:
- Pipeline hazard controller directly downstream of the EX-stage control registers (EX RegWrite, EX MemRead, EX rd).
- Decides each cycle whether IF/ID must stall, whether a bubble goes into ID/EX, and whether to flush on a taken branch.
- Owns a multi-cycle mul/div wait FSM with a cycle counter.
- Keeps a saturating load-use stall counter for on-board performance readout.

Parameters:
- RegAddrBits, 5, register index width.
- MulDivCycles, 32, total stall cycles per mul/div op; legal range 1..255.
- StatBits, 16, width of the load-use stall counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- ClockEnable  in  1  state advances only when ClockEnable&Tick.
- Tick  in  1  global step tick.
- ID_rs1  in  RegAddrBits  source reg 1 of the instruction in ID.
- ID_rs2  in  RegAddrBits  source reg 2 of the instruction in ID.
- ID_UsesRs1  in  1  ID instruction reads rs1.
- ID_UsesRs2  in  1  ID instruction reads rs2.
- EX_RegWrite  in  1  EX instruction writes the register file.
- EX_MemRead  in  1  EX instruction is a load.
- EX_rd  in  RegAddrBits  EX destination register.
- EX_MulDivStart  in  1  EX instruction is mul/div (level, valid in RUN only).
- EX_BranchTaken  in  1  EX resolved a taken branch/jump.
- StallPC  out  1  hold PC.
- StallIFID  out  1  hold IF/ID register.
- StallIDEX  out  1  hold ID/EX register.
- FlushIFID  out  1  zero IF/ID contents.
- FlushIDEX  out  1  insert bubble into ID/EX.
- MulDivBusy  out  1  FSM in MULDIV_WAIT.
- LoadUseStalls  out  StatBits  saturating count of load-use bubbles.

Behaviour:
- Advance = ClockEnable&Tick. All registers update on rising Clock only when Advance=1. Reset overrides asynchronously.
- Registered state: FSM {RUN, MULDIV_WAIT}, cnt[7:0], LoadUseStalls.
- Reset values: RUN, cnt=0, LoadUseStalls=0. All outputs are 0 while Reset=1 and whenever idle inputs are present in RUN.
- Outputs are combinational from state and current inputs. Zero latency: the stall applies in the same cycle the hazard is visible.
- LU (load-use) = EX_RegWrite & EX_MemRead & (EX_rd!=0) & ((ID_UsesRs1 & ID_rs1==EX_rd) | (ID_UsesRs2 & ID_rs2==EX_rd)).
- RUN priority, highest first:
  1. EX_BranchTaken: FlushIFID=1, FlushIDEX=1, no stalls. Stays in RUN. LU and MulDivStart are ignored this cycle.
  2. EX_MulDivStart: StallPC=StallIFID=StallIDEX=1. On Advance: next=MULDIV_WAIT, cnt=MulDivCycles-1.
  3. LU: StallPC=StallIFID=1, FlushIDEX=1. Stays in RUN. On Advance, LoadUseStalls increments, saturating at all-ones.
  4. Otherwise all outputs 0.
- MULDIV_WAIT:
  - MulDivBusy=1.
  - If cnt!=0: StallPC=StallIFID=StallIDEX=1; on Advance cnt decrements.
  - If cnt==0: all stalls 0; on Advance next=RUN.
  - EX_BranchTaken, LU and EX_MulDivStart are ignored; no flushes are issued.
- Total stall cycles per mul/div (Advance every cycle) = MulDivCycles, counting the start cycle.
- Back-to-back mul/div: after returning to RUN, a new EX_MulDivStart restarts the sequence.
- Advance=0: state frozen, outputs still track inputs combinationally. A stall may therefore persist across multiple non-advancing cycles without counting extra stalls.
- rd=0 never causes a load-use stall.
- Reset asserted mid-MULDIV_WAIT returns to RUN immediately; stalls drop in the same cycle.

Test Plan:
- Reset pulse, all inputs 0, Tick=ClockEnable=1 -> all outputs 0, LoadUseStalls=0.
- EX_MemRead=EX_RegWrite=1, EX_rd=5, ID_rs2=5, ID_UsesRs2=1 for 1 cycle -> StallPC=StallIFID=FlushIDEX=1 that cycle; LoadUseStalls=1 after edge. Repeat with EX_rd=0 -> no stall.
- Same load-use plus EX_BranchTaken=1 -> FlushIFID=FlushIDEX=1, StallPC=0, LoadUseStalls unchanged.
- MulDivCycles=4, EX_MulDivStart=1 one cycle -> stalls high exactly 4 cycles; MulDivBusy high 4 cycles (cycles 2-5); RUN on cycle 6. Branch input during wait -> no flush.
- Mul/div started, Tick low for 3 cycles mid-wait -> cnt frozen, stalls held; total stall length = 4 Tick cycles plus 3.
- Reset asserted at cnt=2 -> MulDivBusy and stalls 0 immediately, state RUN. Also: 65540 load-use cycles with StatBits=16 -> LoadUseStalls=16'hFFFF.
